// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle MIPS control unit.
// Holds the FSM state encoding, opcode/funct constants, ALU operation codes,
// datapath select encodings and the per-state control word decode.
package mc_pkg;

  // FSM states, 4-bit encoding; codes 13..15 are unused.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // aluop: request from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alucontrol codes driven to the ALU
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word produced for each state
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       retire;
  } ctrl_t;

  // Control word for a given state; every field not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = SRCB_FOUR;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE: begin
        c.alusrcb = SRCB_IMMSH;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        c.iord = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.retire   = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
        c.retire  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      ADDIWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
        c.retire  = 1'b1;
      end
      ILLEGAL: begin
        c = '0;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU decoder.
// Ports:
//   aluop      in  2  operation class requested by the FSM
//   funct      in  6  R-type funct field
//   alucontrol out 3  ALU operation code (add for anything unknown)
//   valid      out 1  1 when aluop/funct maps to a supported operation
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  // Map aluop/funct to an ALU operation; unknown codes fall back to add.
  always_comb begin
    alucontrol = ALUC_ADD;
    valid      = 1'b0;
    case (aluop)
      ALUOP_ADD: begin
        alucontrol = ALUC_ADD;
        valid      = 1'b1;
      end
      ALUOP_SUB: begin
        alucontrol = ALUC_SUB;
        valid      = 1'b1;
      end
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD: begin alucontrol = ALUC_ADD; valid = 1'b1; end
          F_SUB: begin alucontrol = ALUC_SUB; valid = 1'b1; end
          F_AND: begin alucontrol = ALUC_AND; valid = 1'b1; end
          F_OR:  begin alucontrol = ALUC_OR;  valid = 1'b1; end
          F_SLT: begin alucontrol = ALUC_SLT; valid = 1'b1; end
          default: begin
            alucontrol = ALUC_ADD;
            valid      = 1'b0;
          end
        endcase
      end
      default: begin
        alucontrol = ALUC_ADD;
        valid      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the MIPS core.
// A Moore FSM sequences the shared datapath through fetch/decode/execute/
// memory/writeback; each instruction takes 3-5 cycles.
// Ports:
//   clk, reset (async, active-high)
//   op, funct      instruction fields from the IR
//   zero           ALU zero flag (only affects pcen in BRANCH)
//   pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol   datapath controls
//   retire         pulse in the last cycle of each instruction
//   err            sticky illegal-instruction flag
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       err
);

  state_t     state_r;
  state_t     next_s;
  ctrl_t      ctrl_r;
  logic       err_r;
  logic [2:0] aluc_s;
  logic       aluvalid_s;

  mc_aludec u_aludec (
    .aluop      (ctrl_r.aluop),
    .funct      (funct),
    .alucontrol (aluc_s),
    .valid      (aluvalid_s)
  );

  // Next-state logic; op is only consulted in DECODE/MEMADR and the decoder
  // valid flag only in EXEC, where the IR is guaranteed stable.
  always_comb begin
    next_s = state_r;
    case (state_r)
      FETCH:  next_s = DECODE;
      DECODE: begin
        case (op)
          OP_LW:    next_s = MEMADR;
          OP_SW:    next_s = MEMADR;
          OP_RTYPE: next_s = EXEC;
          OP_BEQ:   next_s = BRANCH;
          OP_ADDI:  next_s = ADDIEX;
          OP_J:     next_s = JUMP;
          default:  next_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) begin
          next_s = MEMRD;
        end else begin
          next_s = MEMWR;
        end
      end
      MEMRD:  next_s = MEMWB;
      MEMWB:  next_s = FETCH;
      MEMWR:  next_s = FETCH;
      EXEC: begin
        if (aluvalid_s) begin
          next_s = ALUWB;
        end else begin
          next_s = ILLEGAL;
        end
      end
      ALUWB:   next_s = FETCH;
      BRANCH:  next_s = FETCH;
      ADDIEX:  next_s = ADDIWB;
      ADDIWB:  next_s = FETCH;
      JUMP:    next_s = FETCH;
      ILLEGAL: next_s = ILLEGAL;
      // Unused encodings mean a corrupted state register: flag it.
      default: next_s = ILLEGAL;
    endcase
  end

  // State register, registered control word for the next state, sticky err.
  // The control word is registered alongside the state so outputs remain a
  // pure function of the state register, free of next-state glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
      ctrl_r  <= state_ctrl(FETCH);
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= state_ctrl(next_s);
      if (next_s == ILLEGAL) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Write enables are masked by reset so nothing is written while it is held,
  // even though the control register already carries the FETCH values.
  assign pcen       = (ctrl_r.pcwrite | (ctrl_r.branch & zero)) & ~reset;
  assign irwrite    = ctrl_r.irwrite  & ~reset;
  assign memwrite   = ctrl_r.memwrite & ~reset;
  assign regwrite   = ctrl_r.regwrite & ~reset;
  assign retire     = ctrl_r.retire   & ~reset;
  assign iord       = ctrl_r.iord;
  assign regdst     = ctrl_r.regdst;
  assign memtoreg   = ctrl_r.memtoreg;
  assign alusrca    = ctrl_r.alusrca;
  assign alusrcb    = ctrl_r.alusrcb;
  assign pcsrc      = ctrl_r.pcsrc;
  assign alucontrol = aluc_s;
  assign err        = err_r;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed, scoreboard-based bench for mc_controller.
// Expected per-cycle output words are queued when an instruction is issued
// and popped/compared once per cycle, mid-cycle.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, retire, err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .retire(retire), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side state labels
  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4,
                 ST_MW = 5, ST_EX = 6, ST_AW = 7, ST_BR = 8, ST_AX = 9,
                 ST_AWB = 10, ST_J = 11, ST_IL = 12, ST_RST = 13;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //  alusrcb[1:0],pcsrc[1:0],alucontrol[2:0],retire,err}
  logic [16:0] obs_w;
  assign obs_w = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, alucontrol, retire, err};

  logic [16:0] exp_q[$];
  int cmp_count = 0;
  int err_count = 0;
  int mw_cnt = 0, rw_cnt = 0, ret_cnt = 0, cyc_cnt = 0;

  // Reference ALU code for an R-type funct
  function automatic logic [3:0] ref_rtype(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  // Expected output word for one bench state
  function automatic logic [16:0] exp_word(input int st, input logic [2:0] ac,
                                           input logic z);
    logic pe, io, mw, iw, rd, mt, rw, sa, rt, er;
    logic [1:0] sb, ps;
    logic [2:0] alc;
    {pe, io, mw, iw, rd, mt, rw, sa, rt, er} = 10'b0;
    sb = 2'b00; ps = 2'b00; alc = 3'b010;
    case (st)
      ST_F:   begin pe = 1'b1; iw = 1'b1; sb = 2'b01; end
      ST_RST: begin sb = 2'b01; end
      ST_D:   begin sb = 2'b11; end
      ST_MA:  begin sa = 1'b1; sb = 2'b10; end
      ST_MR:  begin io = 1'b1; end
      ST_MWB: begin mt = 1'b1; rw = 1'b1; rt = 1'b1; end
      ST_MW:  begin io = 1'b1; mw = 1'b1; rt = 1'b1; end
      ST_EX:  begin sa = 1'b1; alc = ac; end
      ST_AW:  begin rd = 1'b1; rw = 1'b1; rt = 1'b1; end
      ST_BR:  begin sa = 1'b1; alc = 3'b110; ps = 2'b01; pe = z; rt = 1'b1; end
      ST_AX:  begin sa = 1'b1; sb = 2'b10; end
      ST_AWB: begin rw = 1'b1; rt = 1'b1; end
      ST_J:   begin ps = 2'b10; pe = 1'b1; rt = 1'b1; end
      ST_IL:  begin er = 1'b1; end
      default: begin er = 1'b1; end
    endcase
    return {pe, io, mw, iw, rd, mt, rw, sa, sb, ps, alc, rt, er};
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
    cmp_count++;
    assert (obs === expv) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop one expected word and compare against the current outputs.
  task automatic check_cycle(input string tag);
    logic [16:0] e;
    e = exp_q.pop_front();
    cmp_count++;
    assert (obs_w === e) else begin
      err_count++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_w, e);
    end
    cyc_cnt++;
    if (memwrite) mw_cnt++;
    if (regwrite) rw_cnt++;
    if (retire)   ret_cnt++;
  endtask

  // Check n queued cycles, sampling 3 time units into each cycle.
  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #3;
      check_cycle(tag);
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the expected state path of one instruction.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z);
    logic [3:0] rv;
    rv = ref_rtype(f);
    exp_q.push_back(exp_word(ST_F, 3'b010, z));
    exp_q.push_back(exp_word(ST_D, 3'b010, z));
    case (o)
      6'b100011: begin
        exp_q.push_back(exp_word(ST_MA, 3'b010, z));
        exp_q.push_back(exp_word(ST_MR, 3'b010, z));
        exp_q.push_back(exp_word(ST_MWB, 3'b010, z));
      end
      6'b101011: begin
        exp_q.push_back(exp_word(ST_MA, 3'b010, z));
        exp_q.push_back(exp_word(ST_MW, 3'b010, z));
      end
      6'b000000: begin
        exp_q.push_back(exp_word(ST_EX, rv[2:0], z));
        if (rv[3]) exp_q.push_back(exp_word(ST_AW, 3'b010, z));
        else       exp_q.push_back(exp_word(ST_IL, 3'b010, z));
      end
      6'b000100: exp_q.push_back(exp_word(ST_BR, 3'b010, z));
      6'b001000: begin
        exp_q.push_back(exp_word(ST_AX, 3'b010, z));
        exp_q.push_back(exp_word(ST_AWB, 3'b010, z));
      end
      6'b000010: exp_q.push_back(exp_word(ST_J, 3'b010, z));
      default:   exp_q.push_back(exp_word(ST_IL, 3'b010, z));
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o,
                           input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    push_instr(o, f, z);
    run_n(tag, exp_q.size());
  endtask

  // Pulse reset for one edge, checking the asynchronous reset state.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    exp_q.push_back(exp_word(ST_RST, 3'b010, 1'b0));
    check_cycle(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    @(posedge clk); #1;
    #3;
    exp_q.push_back(exp_word(ST_RST, 3'b010, 1'b0));
    check_cycle("reset_init");
    @(posedge clk); #1;
    reset = 1'b0;

    // lw interrupted by reset in MEMRD
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    push_instr(6'b100011, 6'b000000, 1'b0);
    run_n("lw_abort", 3);
    #3;
    check_cycle("lw_abort_memrd");
    exp_q.delete();
    #1;
    do_reset("reset_mid_memrd");

    // full lw: 5 cycles, one write and one retire at the end
    rw_cnt = 0; ret_cnt = 0; cyc_cnt = 0;
    run_instr("lw", 6'b100011, 6'b000000, 1'b0);
    compare("lw_cycles", cyc_cnt, 5);
    compare("lw_retire", ret_cnt, 1);
    compare("lw_regwrite", rw_cnt, 1);

    // R-type sub then slt
    cyc_cnt = 0;
    run_instr("rtype_sub", 6'b000000, 6'b100010, 1'b0);
    run_instr("rtype_slt", 6'b000000, 6'b101010, 1'b1);
    run_instr("rtype_or", 6'b000000, 6'b100101, 1'b0);
    compare("rtype_cycles", cyc_cnt, 12);

    // beq taken then not taken
    cyc_cnt = 0; ret_cnt = 0;
    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_instr("beq_not_taken", 6'b000100, 6'b000000, 1'b0);
    compare("beq_cycles", cyc_cnt, 6);
    compare("beq_retire", ret_cnt, 2);

    // back-to-back sw, addi, j
    cyc_cnt = 0; ret_cnt = 0; mw_cnt = 0; rw_cnt = 0;
    run_instr("sw", 6'b101011, 6'b000000, 1'b0);
    run_instr("addi", 6'b001000, 6'b000000, 1'b1);
    run_instr("j", 6'b000010, 6'b000000, 1'b0);
    compare("swaddij_cycles", cyc_cnt, 11);
    compare("swaddij_retire", ret_cnt, 3);
    compare("swaddij_memwrite", mw_cnt, 1);
    compare("swaddij_regwrite", rw_cnt, 1);

    // illegal opcode: absorbing, err held
    op = 6'b111111; funct = 6'b000000; zero = 1'b1;
    push_instr(6'b111111, 6'b000000, 1'b1);
    for (int i = 0; i < 20; i++) exp_q.push_back(exp_word(ST_IL, 3'b010, 1'b1));
    run_n("illegal_op", exp_q.size());
    do_reset("reset_after_illegal_op");

    // R-type with unsupported funct
    op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    push_instr(6'b000000, 6'b000000, 1'b0);
    for (int i = 0; i < 20; i++) exp_q.push_back(exp_word(ST_IL, 3'b010, 1'b0));
    run_n("illegal_funct", exp_q.size());
    do_reset("reset_after_illegal_funct");

    // normal operation resumes
    run_instr("addi_after_reset", 6'b001000, 6'b000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
